// File: rtl/sdram_user_master.sv
// rtl/sdram_user_master.sv - requester side of the SDRAM controller user interface
module sdram_user_master #(
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 3,
    parameter int AW     = 4
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [23:0] cmd_addr,
    input  logic [8:0]  cmd_len,
    input  logic [15:0] wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        busy,
    output logic        err,
    input  logic        sdram_init_done,
    input  logic        sdram_busy,
    output logic [23:0] sdram_wr_addr,
    output logic [23:0] sdram_rd_addr,
    output logic [15:0] sdram_wr_data,
    output logic        sdram_wr_req,
    output logic        sdram_rd_req,
    output logic [8:0]  sdwr_bytes,
    output logic [8:0]  sdrd_bytes,
    input  logic        sdram_wr_ack,
    input  logic        sdram_rd_ack,
    input  logic [15:0] sdram_rd_data
);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_WR_FILL,
        S_WR_REQ,
        S_WR_DATA,
        S_RD_REQ,
        S_RD_DATA
    } state_t;

    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [8:0]  MAX_LEN = 9'(DEPTH);

    state_t            state, state_nx;
    logic [15:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [23:0]       addr_q;
    logic [8:0]        len_q;
    logic [8:0]        left_q;
    logic [RD_LAT-1:0] pipe;
    logic              cmd_fire, cmd_bad, fifo_empty;
    logic              wr_ack_on, rd_ack_on, push, pop;

    assign cmd_ready     = (state == S_IDLE) && !sdram_busy;
    assign cmd_fire      = cmd_valid && cmd_ready;
    assign cmd_bad       = (cmd_len == 9'd0) || (cmd_len > MAX_LEN);
    assign fifo_empty    = (count == '0);
    assign wdata_ready   = (count != FULL);
    assign wr_ack_on     = sdram_wr_ack && ((state == S_WR_REQ) || (state == S_WR_DATA));
    assign rd_ack_on     = sdram_rd_ack && ((state == S_RD_REQ) || (state == S_RD_DATA));
    assign pop           = wr_ack_on && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push          = wdata_valid && (wdata_ready || pop);
    assign sdram_wr_req  = (state == S_WR_REQ);
    assign sdram_rd_req  = (state == S_RD_REQ);
    assign sdram_wr_addr = addr_q;
    assign sdram_rd_addr = addr_q;
    assign sdwr_bytes    = len_q;
    assign sdrd_bytes    = len_q;
    assign sdram_wr_data = fifo_empty ? 16'h0000 : mem[rd_ptr];
    assign busy          = (state != S_IDLE) && (state != S_WAIT_INIT);

    // Burst sequencing: one outstanding burst, requests live only in the *_REQ states
    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT_INIT: if (sdram_init_done) state_nx = S_IDLE;
            S_IDLE:      if (cmd_fire && !cmd_bad) state_nx = cmd_write ? S_WR_FILL : S_RD_REQ;
            S_WR_FILL:   if (9'(count) >= len_q) state_nx = S_WR_REQ;
            S_WR_REQ,
            S_WR_DATA:   if (wr_ack_on) state_nx = (left_q == 9'd1) ? S_IDLE : S_WR_DATA;
            S_RD_REQ:    if (rd_ack_on) state_nx = S_RD_DATA;
            S_RD_DATA:   if (rvalid && (left_q == 9'd1)) state_nx = S_IDLE;
            default:     state_nx = S_WAIT_INIT;
        endcase
    end

    // State register
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) state <= S_WAIT_INIT;
        else        state <= state_nx;
    end

    // Command latch and words-remaining counter (acks for writes, rvalid for reads)
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            len_q  <= '0;
            left_q <= '0;
        end else if (cmd_fire && !cmd_bad) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            left_q <= cmd_len;
        end else if (wr_ack_on || ((state == S_RD_DATA) && rvalid)) begin
            if (left_q != 9'd0) left_q <= left_q - 9'd1;
        end
    end

    // FIFO storage, no reset needed since count gates every read
    always_ff @(posedge clk_100m) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Read-valid pipe, read data capture and error pulse
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            pipe   <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            pipe   <= {pipe[RD_LAT-2:0], rd_ack_on};
            rvalid <= pipe[RD_LAT-1];
            if (pipe[RD_LAT-1]) rdata <= sdram_rd_data;
            err    <= (cmd_fire && cmd_bad) || (wr_ack_on && fifo_empty);
        end
    end

endmodule

// File: tb/tb_sdram_user_master.sv
// tb/tb_sdram_user_master.sv - randomized self-checking bench for sdram_user_master
module tb_sdram_user_master;

    localparam int DEPTH  = 16;
    localparam int RD_LAT = 3;

    logic        clk_100m, rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [23:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic [15:0] wdata;
    logic        wdata_valid, wdata_ready;
    logic [15:0] rdata;
    logic        rvalid, busy, err;
    logic        sdram_init_done, sdram_busy;
    logic [23:0] sdram_wr_addr, sdram_rd_addr;
    logic [15:0] sdram_wr_data;
    logic        sdram_wr_req, sdram_rd_req;
    logic [8:0]  sdwr_bytes, sdrd_bytes;
    logic        sdram_wr_ack, sdram_rd_ack;
    logic [15:0] sdram_rd_data;

    int checks = 0;
    int errors = 0;
    logic [15:0] fq[$];

    sdram_user_master #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .AW(4)) dut (
        .clk_100m(clk_100m), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .err(err),
        .sdram_init_done(sdram_init_done), .sdram_busy(sdram_busy),
        .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
        .sdram_wr_data(sdram_wr_data), .sdram_wr_req(sdram_wr_req),
        .sdram_rd_req(sdram_rd_req), .sdwr_bytes(sdwr_bytes), .sdrd_bytes(sdrd_bytes),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
        .sdram_rd_data(sdram_rd_data)
    );

    initial clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;

    task automatic cyc();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int n);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            wdata = w;
            wdata_valid = 1'b1;
            #1;
            chk("wdata_ready", {31'd0, wdata_ready}, {31'd0, fq.size() < DEPTH});
            if (fq.size() < DEPTH) fq.push_back(w);
            cyc();
        end
        wdata_valid = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [23:0] a, input logic [8:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        #1;
        chk("cmd_ready_accept", {31'd0, cmd_ready}, 32'd1);
        cyc();
        cmd_valid = 1'b0;
        cmd_addr  = 24'($urandom);
        cmd_len   = 9'($urandom);
    endtask

    task automatic serve_write(input int len, input logic [23:0] addr, input int budget);
        int n, t;
        logic [15:0] e;
        t = 0;
        #1;
        while (sdram_wr_req !== 1'b1 && t < budget) begin
            cyc(); #1; t++;
        end
        chk("wr_req_rise", {31'd0, sdram_wr_req}, 32'd1);
        chk("wr_addr", {8'd0, sdram_wr_addr}, {8'd0, addr});
        chk("wr_bytes", {23'd0, sdwr_bytes}, 32'(len));
        n = 0;
        t = 0;
        while (n < len && t < 200) begin
            sdram_wr_ack = ($urandom_range(0, 3) != 0);
            #1;
            chk("wr_req_hold", {31'd0, sdram_wr_req}, {31'd0, n == 0});
            if (sdram_wr_ack) begin
                e = fq.pop_front();
                chk("wr_data", {16'd0, sdram_wr_data}, {16'd0, e});
                n++;
            end
            cyc();
            t++;
        end
        sdram_wr_ack = 1'b0;
        #1;
        chk("wr_done_busy", {31'd0, busy}, 32'd0);
        chk("wr_done_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic serve_read(input int len, input logic [23:0] addr, input bit dense);
        int c, acks, got;
        int ack_q[$];
        int due_q[$];
        logic [15:0] dat_q[$];
        logic [15:0] d;
        c = 0;
        #1;
        while (sdram_rd_req !== 1'b1 && c < 20) begin
            cyc(); #1; c++;
        end
        chk("rd_req_rise", {31'd0, sdram_rd_req}, 32'd1);
        chk("rd_addr", {8'd0, sdram_rd_addr}, {8'd0, addr});
        chk("rd_bytes", {23'd0, sdrd_bytes}, 32'(len));
        c = 0; acks = 0; got = 0;
        while (got < len && c < 300) begin
            sdram_rd_ack = (acks < len) && (dense || $urandom_range(0, 2) != 0);
            d = 16'($urandom);
            if (ack_q.size() > 0 && ack_q[0] == c - RD_LAT) begin
                void'(ack_q.pop_front());
                due_q.push_back(c + 1);
                dat_q.push_back(d);
            end
            sdram_rd_data = d;
            #1;
            chk("rd_req_hold", {31'd0, sdram_rd_req}, {31'd0, acks == 0});
            if (due_q.size() > 0 && due_q[0] == c) begin
                chk("rvalid_word", {31'd0, rvalid}, 32'd1);
                chk("rdata", {16'd0, rdata}, {16'd0, dat_q[0]});
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
                got++;
            end else begin
                chk("rvalid_quiet", {31'd0, rvalid}, 32'd0);
            end
            if (sdram_rd_ack) begin
                ack_q.push_back(c);
                acks++;
            end
            cyc();
            c++;
        end
        sdram_rd_ack = 1'b0;
        #1;
        chk("rd_done_count", 32'(got), 32'(len));
        chk("rd_done_busy", {31'd0, busy}, 32'd0);
        chk("rd_done_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic bad_len(input logic [8:0] l);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 24'($urandom);
        cmd_len   = l;
        cyc();
        cmd_valid = 1'b0;
        #1;
        chk("bad_err_pulse", {31'd0, err}, 32'd1);
        chk("bad_busy", {31'd0, busy}, 32'd0);
        chk("bad_no_wr_req", {31'd0, sdram_wr_req}, 32'd0);
        cyc();
        chk("bad_err_clear", {31'd0, err}, 32'd0);
        chk("bad_stays_idle", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata = '0; wdata_valid = 1'b0;
        sdram_init_done = 1'b0; sdram_busy = 1'b0;
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_rd_data = '0;
        repeat (3) cyc();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_wdata_ready", {31'd0, wdata_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_reqs", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_wr_data", {16'd0, sdram_wr_data}, 32'd0);
        rst_n = 1'b1;

        // Init gating
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc();
            chk("init_gate", {31'd0, cmd_ready}, 32'd0);
        end
        sdram_init_done = 1'b1;
        #1;
        chk("init_same_cycle", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        cyc();
        chk("init_ready", {31'd0, cmd_ready}, 32'd1);
        sdram_busy = 1'b1;
        #1;
        chk("ctrl_busy_blocks", {31'd0, cmd_ready}, 32'd0);
        sdram_busy = 1'b0;
        cyc();

        // Write burst, 4 words
        push_words(4);
        issue(1'b1, 24'h012345, 9'd4);
        serve_write(4, 24'h012345, 20);

        // Write waits for buffered data
        push_words(1);
        issue(1'b1, 24'hA0B0C0, 9'd3);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fill_no_req", {31'd0, sdram_wr_req}, 32'd0);
            chk("fill_busy", {31'd0, busy}, 32'd1);
            cyc();
        end
        push_words(2);
        serve_write(3, 24'hA0B0C0, 2);

        // Reads: dense len 2, then random-gap bursts
        issue(1'b0, 24'h3FFE01, 9'd2);
        serve_read(2, 24'h3FFE01, 1'b1);
        for (int k = 0; k < 3; k++) begin
            logic [23:0] a;
            int l;
            a = 24'($urandom);
            l = $urandom_range(1, DEPTH);
            issue(1'b0, a, 9'(l));
            serve_read(l, a, 1'b0);
        end

        // Illegal lengths
        bad_len(9'd0);
        bad_len(9'd17);
        bad_len(9'd300);

        // FIFO full, wrap and order
        push_words(17);
        #1;
        chk("fifo_full", {31'd0, wdata_ready}, 32'd0);
        issue(1'b1, 24'h111111, 9'd8);
        serve_write(8, 24'h111111, 20);
        issue(1'b1, 24'h222222, 9'd8);
        serve_write(8, 24'h222222, 20);
        push_words(16);
        issue(1'b1, 24'h333333, 9'd16);
        serve_write(16, 24'h333333, 20);

        // Reset mid-read
        push_words(5);
        issue(1'b0, 24'h0ABCDE, 9'd4);
        #1;
        for (int t = 0; t < 20 && sdram_rd_req !== 1'b1; t++) begin
            cyc(); #1;
        end
        chk("pre_rst_rd_req", {31'd0, sdram_rd_req}, 32'd1);
        sdram_rd_ack = 1'b1;
        cyc();
        sdram_rd_ack = 1'b0;
        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        #1;
        chk("arst_rd_req", {31'd0, sdram_rd_req}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("arst_wdata_ready", {31'd0, wdata_ready}, 32'd1);
        fq.delete();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_wait_init", {31'd0, cmd_ready}, 32'd0);
            chk("post_rst_rvalid", {31'd0, rvalid}, 32'd0);
        end
        sdram_init_done = 1'b1;
        cyc();
        chk("post_rst_idle", {31'd0, cmd_ready}, 32'd1);
        push_words(4);
        issue(1'b1, 24'h00F00D, 9'd4);
        serve_write(4, 24'h00F00D, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
